// File: rtl/regfile_mp_sb_if.sv
// rtl/regfile_mp_sb_if.sv - write, reserve, read and clear bus of the multi-port scoreboarded register file
interface regfile_mp_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                wr_en;
  logic [AW-1:0]       wr_idx_in;
  logic [XLEN-1:0]     wr_data_in;
  logic [NRD*AW-1:0]   rd_idx_in;
  logic [NRD*XLEN-1:0] rd_data_out;
  logic [NRD-1:0]      rd_pend_out;
  logic                rsv_en;
  logic [AW-1:0]       rsv_idx_in;
  logic [NREGS-1:0]    pend_out;
  logic                clr_req_in;
  logic                clr_busy_out;

  modport master (
    output wr_en, wr_idx_in, wr_data_in, rd_idx_in, rsv_en, rsv_idx_in, clr_req_in,
    input  rd_data_out, rd_pend_out, pend_out, clr_busy_out
  );

  modport slave (
    input  wr_en, wr_idx_in, wr_data_in, rd_idx_in, rsv_en, rsv_idx_in, clr_req_in,
    output rd_data_out, rd_pend_out, pend_out, clr_busy_out
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - register file with x0=0, per-register pending bits and a sequential clear sweep
// Optional write-to-read forwarding: REGFILE_BYPASS_EN
module regfile_mp_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic            clkin,
  input  logic            nrst_in,
  regfile_mp_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q;
  logic [XLEN-1:0]   regs_q [NREGS];
  logic [NREGS-1:0]  pend_q;
  logic              idle, wr_ok, rsv_ok, clr_last;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;

  assign idle     = (state_q == IDLE);
  assign wr_ok    = bus.wr_en  && idle && (bus.wr_idx_in  != '0);
  assign rsv_ok   = bus.rsv_en && idle && (bus.rsv_idx_in != '0);
  assign clr_last = (cnt_q == AW'(NREGS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clr_req_in) state_d = CLEAR;
      CLEAR:   if (clr_last)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The sweep starts at 1: entry 0 is never written, so it needs no clearing.
  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (idle && bus.clr_req_in)
        cnt_q <= AW'(1);
      else if (!idle && !clr_last)
        cnt_q <= cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (!idle) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.wr_idx_in] <= bus.wr_data_in;
    end
  end

  // Reserve is applied after the writeback clear so a same-index reserve keeps the entry pending.
  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      pend_q <= '0;
    end else if (!idle) begin
      pend_q[cnt_q] <= 1'b0;
    end else begin
      if (wr_ok)  pend_q[bus.wr_idx_in]  <= 1'b0;
      if (rsv_ok) pend_q[bus.rsv_idx_in] <= 1'b1;
    end
  end

  always_comb begin
    logic [AW-1:0] idx;
    idx     = '0;
    rd_data = '0;
    rd_pend = '0;
    for (int k = 0; k < NRD; k++) begin
      idx = bus.rd_idx_in[k*AW +: AW];
      if (idx != '0) begin
        rd_data[k*XLEN +: XLEN] = regs_q[idx];
        rd_pend[k]              = pend_q[idx];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.wr_idx_in == idx)) begin
          rd_data[k*XLEN +: XLEN] = bus.wr_data_in;
          rd_pend[k]              = rsv_ok && (bus.rsv_idx_in == idx);
        end
`endif
      end
    end
  end

  assign bus.rd_data_out  = rd_data;
  assign bus.rd_pend_out  = rd_pend;
  assign bus.pend_out     = pend_q;
  assign bus.clr_busy_out = !idle;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - randomized self-checking bench for regfile_mp_sb against an array model
module tb_regfile_mp_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clkin = 1'b0;
  logic nrst_in = 1'b0;
  always #5 clkin = ~clkin;

  regfile_mp_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clkin   (clkin),
    .nrst_in (nrst_in),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  bit          m_busy;
  int          m_next;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_next = 0;
  endtask

  function automatic bit wr_acc();
    return bus.wr_en && !m_busy && (bus.wr_idx_in != 0);
  endfunction

  function automatic bit rsv_acc();
    return bus.rsv_en && !m_busy && (bus.rsv_idx_in != 0);
  endfunction

  function automatic logic [31:0] exp_rd(input int idx);
    if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_acc() && int'(bus.wr_idx_in) == idx) return bus.wr_data_in;
`endif
    return m_regs[idx];
  endfunction

  function automatic bit exp_pend(input int idx);
    if (idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_acc() && int'(bus.wr_idx_in) == idx)
      return rsv_acc() && int'(bus.rsv_idx_in) == idx;
`endif
    return m_pend[idx];
  endfunction

  task automatic check_outputs(input string ph);
    logic [31:0] pv;
    int idx;
    for (int k = 0; k < NRD; k++) begin
      idx = int'(bus.rd_idx_in[k*AW +: AW]);
      check($sformatf("%s rd%0d_data x%0d", ph, k, idx), 64'(bus.rd_data_out[k*XLEN +: XLEN]), 64'(exp_rd(idx)));
      check($sformatf("%s rd%0d_pend x%0d", ph, k, idx), 64'(bus.rd_pend_out[k]), 64'(exp_pend(idx)));
    end
    for (int i = 0; i < NREGS; i++) pv[i] = m_pend[i];
    check({ph, " pend_out"}, 64'(bus.pend_out), 64'(pv));
    check({ph, " clr_busy"}, 64'(bus.clr_busy_out), 64'(m_busy));
  endtask

  task automatic model_edge();
    if (m_busy) begin
      m_regs[m_next] = '0;
      m_pend[m_next] = 1'b0;
      if (m_next == NREGS - 1) m_busy = 1'b0;
      else m_next++;
    end else begin
      if (wr_acc()) begin
        m_regs[bus.wr_idx_in] = bus.wr_data_in;
        m_pend[bus.wr_idx_in] = 1'b0;
      end
      if (rsv_acc()) m_pend[bus.rsv_idx_in] = 1'b1;
      if (bus.clr_req_in) begin
        m_busy = 1'b1;
        m_next = 1;
      end
    end
  endtask

  task automatic cycle(input string ph);
    @(negedge clkin);
    check_outputs(ph);
    @(posedge clkin);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_en = 1'b0; bus.wr_idx_in = '0; bus.wr_data_in = '0;
    bus.rsv_en = 1'b0; bus.rsv_idx_in = '0;
    bus.clr_req_in = 1'b0; bus.rd_idx_in = '0;
  endtask

  task automatic set_rd(input int a, input int b);
    bus.rd_idx_in = {AW'(b), AW'(a)};
  endtask

  task automatic do_write(input int idx, input logic [31:0] d, input string ph);
    bus.wr_en = 1'b1; bus.wr_idx_in = AW'(idx); bus.wr_data_in = d;
    cycle(ph);
    bus.wr_en = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 1; i < NREGS; i++) do_write(i, $urandom | 32'h1, "fill");
  endtask

  task automatic read_all(input string ph);
    for (int i = 0; i < NREGS; i++) begin
      set_rd(i, NREGS - 1 - i);
      cycle(ph);
    end
  endtask

  task automatic random_inputs(input int clr_odds);
    bus.wr_en      = 1'($urandom_range(0, 1));
    bus.wr_idx_in  = AW'($urandom_range(0, NREGS - 1));
    bus.wr_data_in = $urandom;
    bus.rsv_en     = ($urandom_range(0, 2) == 0);
    bus.rsv_idx_in = ($urandom_range(0, 3) == 0) ? bus.wr_idx_in : AW'($urandom_range(0, NREGS - 1));
    bus.clr_req_in = (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1);
    if ($urandom_range(0, 2) == 0) set_rd(int'(bus.wr_idx_in), $urandom_range(0, NREGS - 1));
    else set_rd($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1));
  endtask

  task automatic sweep_and_count(input string ph);
    int busy_cnt;
    bus.clr_req_in = 1'b1;
    cycle({ph, " req"});
    bus.clr_req_in = 1'b0;
    busy_cnt = bus.clr_busy_out ? 1 : 0;
    for (int c = 0; c < 60 && bus.clr_busy_out; c++) begin
      random_inputs(3);
      cycle({ph, " sweep"});
      if (bus.clr_busy_out) busy_cnt++;
    end
    drive_idle();
    check({ph, " busy_cycles"}, 64'(busy_cnt), 64'(NREGS - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    model_reset();
    #12;
    for (int i = 0; i < NREGS; i++) begin
      set_rd(i, NREGS - 1 - i);
      #1;
      check_outputs("in_reset");
    end
    @(negedge clkin);
    nrst_in = 1'b1;
    @(posedge clkin);
    #1;
    read_all("post_reset");

    do_write(5, 32'hDEADBEEF, "wr_x5");
    set_rd(5, 0);
    cycle("rd_x5");
    check("x5 value", 64'(bus.rd_data_out[31:0]), 64'h0000_0000_DEAD_BEEF);
    do_write(0, 32'h1234, "wr_x0");
    set_rd(0, 0);
    cycle("rd_x0");

    bus.rsv_en = 1'b1; bus.rsv_idx_in = AW'(7);
    cycle("rsv_x7");
    bus.rsv_en = 1'b0;
    set_rd(7, 7);
    #1;
    check("x7 reserved pend", 64'(bus.pend_out[7]), 64'd1);
    check("x7 reserved rd_pend", 64'(bus.rd_pend_out[0]), 64'd1);
    set_rd(0, 0);
    do_write(7, 32'h55, "wr_x7");
    set_rd(7, 0);
    #1;
    check("x7 written pend", 64'(bus.pend_out[7]), 64'd0);
    set_rd(0, 0);
    bus.rsv_en = 1'b1; bus.rsv_idx_in = AW'(7);
    do_write(7, 32'h66, "wr_rsv_x7");
    bus.rsv_en = 1'b0;
    set_rd(7, 0);
    #1;
    check("x7 wr+rsv data", 64'(bus.rd_data_out[31:0]), 64'h66);
    check("x7 wr+rsv pend", 64'(bus.pend_out[7]), 64'd1);

    do_write(3, 32'h1111_1111, "wr_x3_old");
    set_rd(3, 3);
    bus.wr_en = 1'b1; bus.wr_idx_in = AW'(3); bus.wr_data_in = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x3 same-cycle read", 64'(bus.rd_data_out[31:0]), 64'hA5A5_A5A5);
    check("x3 same-cycle pend", 64'(bus.rd_pend_out[0]), 64'd0);
`else
    check("x3 same-cycle read", 64'(bus.rd_data_out[31:0]), 64'h1111_1111);
`endif
    cycle("bypass_x3");
    bus.wr_en = 1'b0;
    cycle("after_x3");

    fill_all();
    sweep_and_count("clr1");
    read_all("after_clr1");

    fill_all();
    bus.rsv_en = 1'b1; bus.rsv_idx_in = AW'(9);
    cycle("rsv_x9");
    drive_idle();
    bus.clr_req_in = 1'b1;
    cycle("clr2 req");
    bus.clr_req_in = 1'b0;
    for (int c = 0; c < 9; c++) cycle("clr2 sweep");
    #2;
    nrst_in = 1'b0;
    model_reset();
    #1;
    check("reset mid-sweep busy", 64'(bus.clr_busy_out), 64'd0);
    check("reset mid-sweep pend", 64'(bus.pend_out), 64'd0);
    for (int i = 0; i < NREGS; i++) begin
      set_rd(i, NREGS - 1 - i);
      #1;
      check_outputs("mid_sweep_reset");
    end
    @(negedge clkin);
    nrst_in = 1'b1;
    @(posedge clkin);
    #1;
    fill_all();
    sweep_and_count("clr3");
    read_all("after_clr3");

    for (int n = 0; n < 800; n++) begin
      random_inputs(50);
      cycle("rand");
    end
    drive_idle();
    for (int c = 0; c < NREGS; c++) cycle("drain");
    read_all("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the core's integer register file: XLEN-wide data, NREGS entries, NRD combinational read ports, one synchronous write port.
- Register 0 hardwired to zero.
- Per-register pending (scoreboard) bits: issue stage reserves a destination, writeback clears it.
- Sequential clear engine zeroes the file on request, one entry per cycle, without a reset.
- Sits between decode/issue and writeback in the RV32I core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 2.
- NRD, 2, number of read ports.
- Derived, not overridable: AW = $clog2(NREGS).

Ports:
- clkin  input  1  core clock, all state updates on rising edge.
- nrst_in  input  1  asynchronous active-low reset.
- wr_en  input  1  writeback strobe.
- wr_idx_in  input  AW  writeback destination index.
- wr_data_in  input  XLEN  writeback data.
- rd_idx_in  input  NRD*AW  read indices; port k uses bits [k*AW +: AW].
- rd_data_out  output  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_pend_out  output  NRD  pending flag of the register addressed by each read port.
- rsv_en  input  1  reserve strobe from issue.
- rsv_idx_in  input  AW  register to mark pending.
- pend_out  output  NREGS  full pending bitmap; bit 0 always 0.
- clr_req_in  input  1  start a clear sweep.
- clr_busy_out  output  1  high while a sweep runs.

Behaviour:
- Reset (async, nrst_in=0):
  - All registers 0, all pending bits 0.
  - Clear FSM to IDLE, clr_busy_out=0.
  - Takes effect immediately, including mid-sweep; the sweep is aborted.
- Reads:
  - Combinational, zero latency.
  - Index 0 always returns 0 with rd_pend_out=0.
- Writes:
  - Accepted at rising edge when wr_en=1, FSM=IDLE, wr_idx_in!=0.
  - Data visible on reads the following cycle.
  - An accepted write clears pend[wr_idx_in].
  - Writes to index 0 are discarded and have no effect.
- Reserve:
  - When rsv_en=1, FSM=IDLE, rsv_idx_in!=0: pend[rsv_idx_in] set at the edge.
  - Reserving an already pending register keeps it pending.
- Same index, same cycle, write and reserve: data written AND pending stays 1 (reserve wins, new producer).
- Write and reserve to different indices in the same cycle: both take effect independently.
- Clear FSM:
  - IDLE: clr_req_in=1 at edge -> CLEAR, counter=1, clr_busy_out=1 from next cycle.
  - CLEAR: each cycle writes 0 to regs[counter] and clears pend[counter], then counter++.
  - CLEAR exits to IDLE after writing counter=NREGS-1; total NREGS-1 busy cycles.
  - clr_busy_out is 0 again in the cycle after the last entry is cleared.
  - During CLEAR, wr_en and rsv_en are ignored (dropped, not queued).
  - clr_req_in during CLEAR is ignored; no restart.
  - Reads during CLEAR return current contents (partially cleared).
- Counter is AW bits and must not wrap past NREGS-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined, read port k:
  - When the same-cycle write is accepted and wr_idx_in==rd_idx_k (nonzero), rd_data_out returns wr_data_in combinationally.
  - rd_pend_out[k] = 0, unless rsv_en targets the same index in that cycle, in which case it is 1.
- Undefined: reads return the registered value and registered pending bit only; no write-to-read forwarding.
- Either way, index 0 is never bypassed.

Test Plan:
- Reset, then read all indices on both ports -> all rd_data_out=0, pend_out=0, clr_busy_out=0.
- Write 0xDEADBEEF to x5; read x5 next cycle -> 0xDEADBEEF. Write 0x1234 to x0 -> x0 still reads 0.
- Reserve x7 -> pend_out[7]=1, rd_pend_out=1 when reading x7. Write x7=0x55 -> pend[7]=0. Same-cycle reserve+write x7=0x66 -> data 0x66, pend[7]=1.
- Fill x1..x31 with nonzero values, pulse clr_req_in -> clr_busy_out high exactly 31 cycles, all reads 0 afterwards. Writes issued during the sweep are lost.
- Assert nrst_in=0 at sweep cycle 10 -> immediate busy=0, all regs 0, IDLE. A new clr_req_in after release starts a full 31-cycle sweep.
- REGFILE_BYPASS_EN defined: write x3=0xA5A5A5A5 while reading x3 same cycle -> rd_data_out=0xA5A5A5A5, rd_pend_out=0. Undefined: old value returned.
